// File: rtl/axi_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : axi_wr_arbiter
// Description : Two-requester AXI write arbiter (AW + W channels) with a
//               registered grant. Round-robin on ties unless
//               AXI_WR_ARB_FIXED_PRI_EN is defined (then m0 always wins).
// Revision    : 1.0 - initial release
// ============================================================================
module axi_wr_arbiter #(
  parameter int AW = 32,
  parameter int DW = 64
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [AW-1:0] m0_awaddr,
  input  logic          m0_awvalid,
  output logic          m0_awready,
  input  logic [DW-1:0] m0_wdata,
  input  logic          m0_wlast,
  input  logic          m0_wvalid,
  output logic          m0_wready,
  input  logic [AW-1:0] m1_awaddr,
  input  logic          m1_awvalid,
  output logic          m1_awready,
  input  logic [DW-1:0] m1_wdata,
  input  logic          m1_wlast,
  input  logic          m1_wvalid,
  output logic          m1_wready,
  output logic [AW-1:0] awaddr,
  output logic          awvalid,
  input  logic          awready,
  output logic [DW-1:0] wdata,
  output logic          wlast,
  output logic          wvalid,
  input  logic          wready,
  output logic          grant,
  output logic          busy,
  output logic          burst_done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } state_t;

  state_t r_state;
  logic   r_grant;
  logic   r_busy;
  logic   r_burst_done;
`ifndef AXI_WR_ARB_FIXED_PRI_EN
  logic   r_last_grant;
`endif

  logic          w_in_addr;
  logic          w_in_data;
  logic          w_winner;
  logic          w_sel_awvalid;
  logic [AW-1:0] w_sel_awaddr;
  logic          w_sel_wvalid;
  logic [DW-1:0] w_sel_wdata;
  logic          w_sel_wlast;

  assign w_in_addr     = (r_state == S_ADDR);
  assign w_in_data     = (r_state == S_DATA);
  assign w_sel_awvalid = r_grant ? m1_awvalid : m0_awvalid;
  assign w_sel_awaddr  = r_grant ? m1_awaddr  : m0_awaddr;
  assign w_sel_wvalid  = r_grant ? m1_wvalid  : m0_wvalid;
  assign w_sel_wdata   = r_grant ? m1_wdata   : m0_wdata;
  assign w_sel_wlast   = r_grant ? m1_wlast   : m0_wlast;

`ifdef AXI_WR_ARB_FIXED_PRI_EN
  assign w_winner = ~m0_awvalid;
`else
  // On a tie the requester that did not own the last burst wins
  assign w_winner = (m0_awvalid & m1_awvalid) ? ~r_last_grant : m1_awvalid;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= S_IDLE;
      r_grant      <= 1'b0;
      r_busy       <= 1'b0;
      r_burst_done <= 1'b0;
`ifndef AXI_WR_ARB_FIXED_PRI_EN
      r_last_grant <= 1'b1;
`endif
    end else begin
      r_burst_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (m0_awvalid | m1_awvalid) begin
            r_grant <= w_winner;
            r_busy  <= 1'b1;
            r_state <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (w_sel_awvalid & awready) begin
            r_state <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_sel_wvalid & wready & w_sel_wlast) begin
            r_state      <= S_IDLE;
            r_busy       <= 1'b0;
            r_burst_done <= 1'b1;
`ifndef AXI_WR_ARB_FIXED_PRI_EN
            r_last_grant <= r_grant;
`endif
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Address/data are zeroed whenever their valid is not forwarded
  assign awvalid    = w_in_addr & w_sel_awvalid;
  assign awaddr     = awvalid ? w_sel_awaddr : '0;
  assign m0_awready = w_in_addr & ~r_grant & awready;
  assign m1_awready = w_in_addr &  r_grant & awready;

  assign wvalid     = w_in_data & w_sel_wvalid;
  assign wdata      = wvalid ? w_sel_wdata : '0;
  assign wlast      = wvalid & w_sel_wlast;
  assign m0_wready  = w_in_data & ~r_grant & wready;
  assign m1_wready  = w_in_data &  r_grant & wready;

  assign grant      = r_grant;
  assign busy       = r_busy;
  assign burst_done = r_burst_done;

endmodule
`default_nettype wire

// File: tb/tb_axi_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_wr_arbiter
// Description : Directed self-checking bench for axi_wr_arbiter (default build).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_wr_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] m0_awaddr, m1_awaddr, awaddr;
  logic        m0_awvalid, m0_awready, m1_awvalid, m1_awready;
  logic [63:0] m0_wdata, m1_wdata, wdata;
  logic        m0_wlast, m0_wvalid, m0_wready;
  logic        m1_wlast, m1_wvalid, m1_wready;
  logic        awvalid, awready, wlast, wvalid, wready;
  logic        grant, busy, burst_done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  axi_wr_arbiter #(.AW(32), .DW(64)) dut (
    .clk(clk), .rstn(rstn),
    .m0_awaddr(m0_awaddr), .m0_awvalid(m0_awvalid), .m0_awready(m0_awready),
    .m0_wdata(m0_wdata), .m0_wlast(m0_wlast), .m0_wvalid(m0_wvalid), .m0_wready(m0_wready),
    .m1_awaddr(m1_awaddr), .m1_awvalid(m1_awvalid), .m1_awready(m1_awready),
    .m1_wdata(m1_wdata), .m1_wlast(m1_wlast), .m1_wvalid(m1_wvalid), .m1_wready(m1_wready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .grant(grant), .busy(busy), .burst_done(burst_done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pat(input int m, input int b);
    return {(m == 0) ? 32'hA0A0_0000 : 32'hB1B1_0000, 32'(b)};
  endfunction

  task automatic drive_w(input int m, input logic v, input logic [63:0] d, input logic l);
    if (m == 0) begin m0_wvalid = v; m0_wdata = d; m0_wlast = l; end
    else        begin m1_wvalid = v; m1_wdata = d; m1_wlast = l; end
  endtask

  task automatic clear_inputs();
    m0_awvalid = 0; m1_awvalid = 0; m0_awaddr = 0; m1_awaddr = 0;
    drive_w(0, 0, 64'd0, 0);
    drive_w(1, 0, 64'd0, 0);
    awready = 0; wready = 0;
  endtask

  // Burst from requester m; mask lists every requester asserting awvalid in IDLE.
  // n_stop < n_total leaves the burst unfinished (used for the reset case).
  task automatic run_burst(input int m, input logic [1:0] mask, input logic [31:0] addr,
                           input int n_total, input int n_stop, input int aw_delay,
                           input bit early_w, input bit toggle_wr, input logic exp_done);
    int  cyc, beat, k, obs;
    bit  hs;
    @(negedge clk);
    m0_awvalid = mask[0];
    m1_awvalid = mask[1];
    m0_awaddr  = (m == 0) ? addr : 32'hDEAD_0000;
    m1_awaddr  = (m == 1) ? addr : 32'hBEEF_0000;
    drive_w(0, 0, 64'd0, 0);
    drive_w(1, 0, 64'd0, 0);
    if (early_w) drive_w(m, 1, pat(m, 0), n_total == 1);
    awready = (aw_delay == 0);
    wready  = 1;
    #1;
    chk("idle_busy", busy, 0);
    chk("idle_burst_done", burst_done, exp_done);
    chk("idle_awvalid", awvalid, 0);
    chk("idle_awready", m0_awready | m1_awready, 0);
    chk("idle_wready", m0_wready | m1_wready, 0);

    cyc = 0; hs = 0;
    while (!hs) begin
      @(negedge clk);
      awready = (cyc >= aw_delay);
      #1;
      chk("addr_awvalid", awvalid, 1);
      chk("addr_awaddr", awaddr, addr);
      chk("addr_grant", grant, m);
      chk("addr_busy", busy, 1);
      chk("addr_sel_awready", (m == 0) ? m0_awready : m1_awready, awready);
      chk("addr_oth_awready", (m == 0) ? m1_awready : m0_awready, 0);
      chk("addr_wready", m0_wready | m1_wready, 0);
      chk("addr_wvalid", wvalid, 0);
      hs = awready;
      cyc++;
    end

    beat = 0; k = 0; obs = 0;
    while (beat < n_stop) begin
      @(negedge clk);
      if (m == 0) m0_awvalid = 0; else m1_awvalid = 0;
      awready = 0;
      drive_w(m, 1, pat(m, beat), beat == n_total - 1);
      drive_w(1 - m, 1, ~pat(m, beat), 1);
      wready = toggle_wr ? (k % 2 == 0) : 1'b1;
      #1;
      chk("data_wvalid", wvalid, 1);
      chk("data_wdata", wdata, pat(m, beat));
      chk("data_wlast", wlast, beat == n_total - 1);
      chk("data_sel_wready", (m == 0) ? m0_wready : m1_wready, wready);
      chk("data_oth_wready", (m == 0) ? m1_wready : m0_wready, 0);
      chk("data_oth_awready", m0_awready | m1_awready, 0);
      chk("data_awvalid", awvalid, 0);
      chk("data_awaddr", awaddr, 0);
      chk("data_grant", grant, m);
      chk("data_burst_done", burst_done, 0);
      if (wvalid && wready) obs++;
      if (wready) beat++;
      k++;
    end
    if (n_stop == n_total) chk("handshake_count", obs, n_total);
  endtask

  initial begin
    rstn = 0;
    clear_inputs();
    m0_awvalid = 1; awready = 1; wready = 1;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_burst_done", burst_done, 0);
    chk("rst_awvalid", awvalid, 0);
    chk("rst_awready", m0_awready, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_wlast", wlast, 0);
    chk("rst_awaddr", awaddr, 0);
    chk("rst_wdata", wdata, 0);
    clear_inputs();
    rstn = 1;

    // Back-to-back ties alternate m0, m1, m0, m1 with an IDLE cycle between
    run_burst(0, 2'b11, 32'h0000_1000, 4, 4, 0, 0, 0, 0);
    run_burst(1, 2'b11, 32'h0000_2000, 4, 4, 0, 0, 0, 1);
    run_burst(0, 2'b11, 32'h0000_3000, 4, 4, 0, 0, 0, 1);
    run_burst(1, 2'b11, 32'h0000_4000, 4, 4, 0, 0, 0, 1);

    // 256-beat m0 burst
    run_burst(0, 2'b01, 32'h0800_0000, 256, 256, 0, 0, 0, 1);

    // m1 presents W early while awready is held off 5 cycles
    run_burst(1, 2'b10, 32'h0900_0040, 8, 8, 5, 1, 0, 1);

    // 16-beat m0 burst with wready toggling while m1 keeps requesting
    run_burst(0, 2'b11, 32'h0A00_0000, 16, 16, 0, 0, 1, 1);

    @(negedge clk);
    clear_inputs();
    #1;
    chk("tail_burst_done", burst_done, 1);
    chk("tail_busy", busy, 0);
    @(negedge clk); #1;
    chk("tail_done_clear", burst_done, 0);
    chk("tail_stays_idle", busy, 0);

    // Reset on beat 100 of a 256-beat burst
    run_burst(0, 2'b01, 32'h0800_0000, 256, 99, 0, 0, 0, 0);
    @(negedge clk);
    drive_w(0, 1, pat(0, 99), 0);
    wready = 1; awready = 1;
    #1;
    rstn = 0;
    #1;
    chk("mid_rst_wvalid", wvalid, 0);
    chk("mid_rst_wlast", wlast, 0);
    chk("mid_rst_wdata", wdata, 0);
    chk("mid_rst_wready", m0_wready | m1_wready, 0);
    chk("mid_rst_awvalid", awvalid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_grant", grant, 0);
    @(posedge clk);
    @(negedge clk);
    clear_inputs();
    rstn = 1;
    #1;
    chk("post_rst_busy", busy, 0);
    chk("post_rst_wvalid", wvalid, 0);
    run_burst(0, 2'b01, 32'h0000_0100, 4, 4, 0, 0, 0, 0);
    @(negedge clk);
    clear_inputs();
    #1;
    chk("post_rst_burst_done", burst_done, 1);
    chk("post_rst_grant", grant, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
